// File: rtl/sd_pkg.sv
// Shared definitions for the SD block-transfer sequencer: command codes, tokens,
// result codes and the sequencer state encoding.
package sd_pkg;

   localparam logic [5:0] CMD17     = 6'd17;
   localparam logic [5:0] CMD24     = 6'd24;
   localparam logic [7:0] TOK_START = 8'hFE;
   localparam logic [4:0] DRESP_OK  = 5'h05;
   localparam logic [7:0] BYTE_IDLE = 8'hFF;

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_R1_TO   = 3'd1;
   localparam logic [2:0] ERR_R1      = 3'd2;
   localparam logic [2:0] ERR_TOK_TO  = 3'd3;
   localparam logic [2:0] ERR_TOKEN   = 3'd4;
   localparam logic [2:0] ERR_WRITE   = 3'd5;
   localparam logic [2:0] ERR_BUSY_TO = 3'd6;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_GAP,
      S_WTOK, S_WDATA, S_WCRC, S_DRESP, S_WBUSY, S_FIN
   } sd_state_t;

   // Byte k (0..5) of the command frame; the trailing CRC byte is sent as FF.
   function automatic logic [7:0] cmd_byte(input logic wr, input logic [31:0] addr,
                                           input logic [2:0] k);
      case (k)
         3'd0:    cmd_byte = {2'b01, (wr ? CMD24 : CMD17)};
         3'd1:    cmd_byte = addr[31:24];
         3'd2:    cmd_byte = addr[23:16];
         3'd3:    cmd_byte = addr[15:8];
         3'd4:    cmd_byte = addr[7:0];
         default: cmd_byte = BYTE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sd_byte_xfer.sv
// Byte-exchange timer: turns a sequencer request into an spi_io pulse and reports
// completion one clock after the last of BYTE_TICKS cespi pulses.
module sd_byte_xfer #(
   parameter int BYTE_TICKS = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic cespi,
   input  logic req,
   output logic spi_io,
   output logic ack
);

   localparam int CW = $clog2(BYTE_TICKS + 1);

   logic          active;
   logic [CW-1:0] ticks;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         spi_io <= 1'b0;
         ack    <= 1'b0;
         active <= 1'b0;
         ticks  <= '0;
      end else begin
         spi_io <= 1'b0;
         ack    <= 1'b0;
         if (!active) begin
            if (req) begin
               spi_io <= 1'b1;
               active <= 1'b1;
               ticks  <= '0;
            end
         // the cespi coinciding with the spi_io pulse belongs to no bit yet
         end else if (!spi_io && cespi) begin
            ticks <= ticks + 1'b1;
            if (ticks == CW'(BYTE_TICKS - 1)) begin
               active <= 1'b0;
               ack    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sd_block_ctrl.sv
// Single-block CMD17/CMD24 sequencer: drives the SPI byte engine through the SD
// command/response/token protocol and moves one 512-byte sector to or from the buffer.
module sd_block_ctrl
   import sd_pkg::*;
#(
   parameter int BYTE_TICKS = 16,
   parameter int NCR_MAX    = 8,
   parameter int TOKEN_MAX  = 4096,
   parameter int BUSY_MAX   = 65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cespi,
   input  logic        start,
   input  logic        wr,
   input  logic        sdhc,
   input  logic [31:0] lba,
   output logic        busy,
   output logic        done,
   output logic [2:0]  err,
   output logic        own,
   output logic        cs,
   output logic        spi_io,
   output logic [7:0]  spi_d,
   input  logic [7:0]  spi_q,
   output logic [8:0]  buf_a,
   output logic        buf_we,
   output logic [7:0]  buf_d,
   input  logic [7:0]  buf_q
);

   sd_state_t   state_q, state_n;
   logic        pend_q, pend_n;
   logic        hold_q, hold_n;
   logic [8:0]  cnt_q, cnt_n;
   logic [15:0] poll_q, poll_n, poll_inc;
   logic [2:0]  err_q, err_n;
   logic [7:0]  spi_d_q, spi_d_n;
   logic [8:0]  buf_a_q, buf_a_n;
   logic [7:0]  buf_d_q, buf_d_n;
   logic        buf_we_q, buf_we_n;
   logic        done_q, done_n;
   logic        busy_q, busy_n;
   logic        cs_q, cs_n;
   logic        wr_q, wr_n;
   logic [31:0] addr_q, addr_n;
   logic        req, ack;
   logic        to_fin;
   logic [2:0]  fin_err;
   logic [7:0]  tx_byte;
   logic        last_byte;

   sd_byte_xfer #(.BYTE_TICKS(BYTE_TICKS)) u_xfer (
      .clock  (clock),
      .reset  (reset),
      .cespi  (cespi),
      .req    (req),
      .spi_io (spi_io),
      .ack    (ack)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pend_q   <= 1'b0;
         hold_q   <= 1'b0;
         cnt_q    <= '0;
         poll_q   <= '0;
         err_q    <= ERR_OK;
         spi_d_q  <= BYTE_IDLE;
         buf_a_q  <= '0;
         buf_d_q  <= '0;
         buf_we_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         cs_q     <= 1'b1;
         wr_q     <= 1'b0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_n;
         pend_q   <= pend_n;
         hold_q   <= hold_n;
         cnt_q    <= cnt_n;
         poll_q   <= poll_n;
         err_q    <= err_n;
         spi_d_q  <= spi_d_n;
         buf_a_q  <= buf_a_n;
         buf_d_q  <= buf_d_n;
         buf_we_q <= buf_we_n;
         done_q   <= done_n;
         busy_q   <= busy_n;
         cs_q     <= cs_n;
         wr_q     <= wr_n;
         addr_q   <= addr_n;
      end
   end

   // Byte to transmit for the exchange about to be issued in the current state.
   always_comb begin
      tx_byte = BYTE_IDLE;
      case (state_q)
         S_CMD:   tx_byte = cmd_byte(wr_q, addr_q, cnt_q[2:0]);
         S_WTOK:  tx_byte = TOK_START;
         S_WDATA: tx_byte = buf_q;
         default: tx_byte = BYTE_IDLE;
      endcase
   end

   always_comb begin
      state_n   = state_q;
      pend_n    = pend_q;
      hold_n    = hold_q;
      cnt_n     = cnt_q;
      poll_n    = poll_q;
      err_n     = err_q;
      spi_d_n   = spi_d_q;
      buf_a_n   = buf_a_q;
      buf_d_n   = buf_d_q;
      buf_we_n  = 1'b0;
      done_n    = 1'b0;
      busy_n    = busy_q;
      cs_n      = cs_q;
      wr_n      = wr_q;
      addr_n    = addr_q;
      req       = 1'b0;
      to_fin    = 1'b0;
      fin_err   = ERR_OK;
      poll_inc  = poll_q + 16'd1;
      last_byte = (cnt_q == 9'd511);

      if (state_q == S_IDLE) begin
         if (start) begin
            wr_n    = wr;
            addr_n  = sdhc ? lba : {lba[22:0], 9'd0};
            busy_n  = 1'b1;
            cs_n    = 1'b0;
            err_n   = ERR_OK;
            cnt_n   = '0;
            poll_n  = '0;
            pend_n  = 1'b0;
            hold_n  = 1'b0;
            state_n = S_CMD;
         end
      end else if (!pend_q) begin
         // One idle clock after each completion lets buf_q settle on the new buf_a.
         if (hold_q) begin
            hold_n = 1'b0;
         end else begin
            req     = 1'b1;
            pend_n  = 1'b1;
            spi_d_n = tx_byte;
         end
      end else if (ack) begin
         pend_n = 1'b0;
         hold_n = 1'b1;
         case (state_q)
            S_CMD: begin
               cnt_n = cnt_q + 9'd1;
               if (cnt_q == 9'd5) begin
                  cnt_n   = '0;
                  poll_n  = '0;
                  state_n = S_R1;
               end
            end
            S_R1: begin
               if (spi_q[7]) begin
                  if (poll_inc == 16'(NCR_MAX)) begin
                     to_fin  = 1'b1;
                     fin_err = ERR_R1_TO;
                  end else begin
                     poll_n = poll_inc;
                  end
               end else if (spi_q != 8'h00) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_R1;
               end else begin
                  poll_n  = '0;
                  state_n = wr_q ? S_GAP : S_TOKEN;
               end
            end
            S_TOKEN: begin
               if (spi_q == TOK_START) begin
                  cnt_n   = '0;
                  state_n = S_DATA;
               end else if (spi_q[7:4] == 4'h0) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_TOKEN;
               end else if (poll_inc == 16'(TOKEN_MAX)) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_TOK_TO;
               end else begin
                  poll_n = poll_inc;
               end
            end
            S_DATA: begin
               buf_we_n = 1'b1;
               buf_a_n  = cnt_q;
               buf_d_n  = spi_q;
               cnt_n    = cnt_q + 9'd1;
               if (last_byte) state_n = S_CRC;
            end
            S_CRC: begin
               cnt_n = cnt_q + 9'd1;
               if (cnt_q[0]) to_fin = 1'b1;
            end
            S_GAP:  state_n = S_WTOK;
            S_WTOK: begin
               cnt_n   = '0;
               buf_a_n = '0;
               state_n = S_WDATA;
            end
            S_WDATA: begin
               cnt_n   = cnt_q + 9'd1;
               buf_a_n = cnt_q + 9'd1;
               if (last_byte) state_n = S_WCRC;
            end
            S_WCRC: begin
               cnt_n = cnt_q + 9'd1;
               if (cnt_q[0]) begin
                  cnt_n   = '0;
                  poll_n  = '0;
                  state_n = S_DRESP;
               end
            end
            S_DRESP: begin
               if (spi_q != 8'hFF && spi_q[4:0] == DRESP_OK) begin
                  poll_n  = '0;
                  state_n = S_WBUSY;
               end else if (spi_q != 8'hFF && !spi_q[4]) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_WRITE;
               end else if (poll_inc == 16'(NCR_MAX)) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_WRITE;
               end else begin
                  poll_n = poll_inc;
               end
            end
            S_WBUSY: begin
               if (spi_q != 8'h00) begin
                  to_fin = 1'b1;
               end else if (poll_inc == 16'(BUSY_MAX)) begin
                  to_fin  = 1'b1;
                  fin_err = ERR_BUSY_TO;
               end else begin
                  poll_n = poll_inc;
               end
            end
            S_FIN: begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               cnt_n   = '0;
               state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
         // Every ending, good or bad, deselects the card before the trailing byte.
         if (to_fin) begin
            err_n   = fin_err;
            cs_n    = 1'b1;
            state_n = S_FIN;
         end
      end
   end

   assign busy   = busy_q;
   assign own    = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign cs     = cs_q;
   assign spi_d  = spi_d_q;
   assign buf_a  = buf_a_q;
   assign buf_we = buf_we_q;
   assign buf_d  = buf_d_q;

endmodule
